// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants one of NUM_CH requesters ownership of a shared
// memory bus. Ownership lasts while the owner holds its request and is
// followed by TURN_CYC dead cycles. The owner's address is steered to
// either the external SRAM (below MAP_BASE) or the mapped-register space.
//
// Ports
//   i_clk, i_reset     clock (rising edge), asynchronous active-high reset
//   i_req[NUM_CH]      per-channel request, held for the whole access
//   i_addr             packed addresses, channel k at [k*ADDR_W +: ADDR_W]
//   i_wr[NUM_CH]       per-channel write strobe
//   i_force_en/_ch     restrict eligibility to a single channel
//   i_disableDrive     suppress external bus drive for this cycle
//   o_grant            registered one-hot grant (or zero)
//   o_memAddr/o_memWr  owner's address and write strobe (0 outside OWN)
//   o_memExtEn         external SRAM enable
//   o_memMapEn         mapped-register enable
//   o_driveEn          external bus tristate enable
//   o_preempt          one-cycle pulse when forcing removes the owner
module mem_bus_arbiter #(
  parameter int unsigned       NUM_CH   = 3,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] MAP_BASE = ADDR_W'(16'hC000),
  parameter int unsigned       TURN_CYC = 1,
  parameter int unsigned       RR_MODE  = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_CH-1:0]          i_req,
  input  logic [NUM_CH*ADDR_W-1:0]   i_addr,
  input  logic [NUM_CH-1:0]          i_wr,
  input  logic                       i_force_en,
  input  logic [$clog2(NUM_CH)-1:0]  i_force_ch,
  input  logic                       i_disableDrive,
  output logic [NUM_CH-1:0]          o_grant,
  output logic [ADDR_W-1:0]          o_memAddr,
  output logic                       o_memWr,
  output logic                       o_memExtEn,
  output logic                       o_memMapEn,
  output logic                       o_driveEn,
  output logic                       o_preempt
);

  localparam int unsigned IDX_W     = $clog2(NUM_CH);
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned TURN_LOAD = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rrPtr;
  logic [CNT_W-1:0]   turnCnt;

  logic [NUM_CH-1:0]  eligible;
  logic               anyEligible;
  logic [IDX_W-1:0]   winner;
  logic               ownerReq;
  logic               ownerWr;
  logic [ADDR_W-1:0]  ownerAddr;
  logic               owning;
  logic               preemptHit;

  // Eligibility: an out-of-range forced index matches no channel.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      eligible[k] = i_req[k] & (~i_force_en | (i_force_ch == IDX_W'(k)));
    end
  end

  assign anyEligible = |eligible;

  // Winner search: fixed mode scans from 0, round-robin scans from the
  // channel after the last grant, wrapping.
  always_comb begin
    int unsigned cand;
    logic        found;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (RR_MODE != 0) ? (32'(rrPtr) + i + 1) % NUM_CH : i;
      if (!found && eligible[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  // Owner-indexed view of the request, strobe and address buses.
  always_comb begin
    ownerReq  = 1'b0;
    ownerWr   = 1'b0;
    ownerAddr = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (owner == IDX_W'(k)) begin
        ownerReq  = i_req[k];
        ownerWr   = i_wr[k];
        ownerAddr = i_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign owning     = (state == OWN);
  assign preemptHit = i_force_en & (owner != i_force_ch);

  // Arbitration FSM with registered grant and preempt pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      o_grant   <= '0;
      owner     <= '0;
      rrPtr     <= IDX_W'(NUM_CH - 1);
      turnCnt   <= '0;
      o_preempt <= 1'b0;
    end else begin
      o_preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (anyEligible) begin
            owner   <= winner;
            rrPtr   <= winner;
            o_grant <= NUM_CH'(1) << winner;
            state   <= OWN;
          end
        end
        OWN: begin
          // Release and preempt share one exit; preempt only sets the pulse.
          if (!ownerReq || preemptHit) begin
            o_grant   <= '0;
            o_preempt <= preemptHit;
            if (TURN_CYC == 0) begin
              state <= IDLE;
            end else begin
              state   <= TURN;
              turnCnt <= CNT_W'(TURN_LOAD);
            end
          end
        end
        TURN: begin
          if (turnCnt == '0) begin
            state <= IDLE;
          end else begin
            turnCnt <= turnCnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= '0;
        end
      endcase
    end
  end

  // Bus steering follows the owner combinationally; the enables also need
  // the owner to still be requesting.
  assign o_memAddr  = owning ? ownerAddr : '0;
  assign o_memWr    = owning & ownerWr;
  assign o_memExtEn = owning & ownerReq & (ownerAddr <  MAP_BASE) & ~i_disableDrive;
  assign o_memMapEn = owning & ownerReq & (ownerAddr >= MAP_BASE);
  assign o_driveEn  = owning & ~i_disableDrive;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of requesting channels, range 2..8.
REQ-002 Parameter ADDR_W, default 16, address width per channel.
REQ-003 Parameter MAP_BASE, default 16'hC000, lowest memory-mapped address; addresses below it are external SRAM.
REQ-004 Parameter TURN_CYC, default 1, dead cycles between owners, range 0..7.
REQ-005 Parameter RR_MODE, default 0; 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 The block SHALL use one clock, i_clk; reset i_reset SHALL be asynchronous and active-high.
REQ-007 i_clk  in  1  sole clock, rising edge.
REQ-008 i_reset  in  1  asynchronous active-high reset.
REQ-009 i_req  in  NUM_CH  per-channel request, held for the whole access sequence.
REQ-010 i_addr  in  NUM_CH*ADDR_W  packed addresses, channel k at bits [k*ADDR_W +: ADDR_W].
REQ-011 i_wr  in  NUM_CH  per-channel write strobe.
REQ-012 i_force_en  in  1  restricts eligibility to channel i_force_ch (boot/pause ownership).
REQ-013 i_force_ch  in  clog2(NUM_CH)  forced channel index; values >= NUM_CH make no channel eligible.
REQ-014 i_disableDrive  in  1  forbids driving the external bus this cycle.
REQ-015 o_grant  out  NUM_CH  one-hot registered grant, or zero.
REQ-016 o_memAddr, o_memWr  out  ADDR_W, 1  selected bus address and write strobe.
REQ-017 o_memExtEn, o_memMapEn  out  1, 1  external SRAM enable and mapped-register enable.
REQ-018 o_driveEn  out  1  tristate enable for the external bus drivers.
REQ-019 o_preempt  out  1  one-cycle pulse when an owner loses the grant through forcing.

Function
REQ-020 State machine: IDLE (no owner), OWN (grant held by an owner register), TURN (dead cycles).
REQ-021 Eligible channel: i_req[k]=1 and (i_force_en=0 or k=i_force_ch).
REQ-022 IDLE: if any channel is eligible at an edge, the winner SHALL be registered, OWN entered, and o_grant driven one cycle after the request is seen; otherwise the block stays in IDLE.
REQ-023 Winner with RR_MODE=0: lowest eligible index.
REQ-024 Winner with RR_MODE=1: first eligible index after the last granted index, wrapping NUM_CH-1 -> 0.
REQ-025 OWN: the owner SHALL keep the grant while its i_req stays high; no other channel can take the grant.
REQ-026 OWN with the owner's i_req low at an edge: go to TURN, or to IDLE when TURN_CYC=0; o_grant clears on the same edge.
REQ-027 OWN with i_force_en=1 and owner != i_force_ch at an edge: grant clears, o_preempt=1 for one cycle, then take the REQ-026 path.
REQ-028 Release and preempt at the same edge SHALL give one REQ-026 transition, with o_preempt=1.
REQ-029 TURN: a counter SHALL load TURN_CYC-1 on entry and decrement each cycle; on reaching zero the block goes to IDLE; requests are ignored during TURN.
REQ-030 With TURN_CYC>=1, the minimum gap between two grants is TURN_CYC+1 cycles; with TURN_CYC=0 it is 1 cycle (the IDLE cycle).
REQ-031 In OWN, o_memAddr and o_memWr SHALL be the owner's i_addr and i_wr, combinational from the owner register; outside OWN both SHALL be 0.
REQ-032 o_memExtEn = OWN & i_req[owner] & (o_memAddr < MAP_BASE) & ~i_disableDrive.
REQ-033 o_memMapEn = OWN & i_req[owner] & (o_memAddr >= MAP_BASE); it is not gated by i_disableDrive.
REQ-034 o_memExtEn and o_memMapEn SHALL never both be 1.
REQ-035 o_driveEn = OWN & ~i_disableDrive; i_disableDrive SHALL NOT change state, grant or counters.
REQ-036 Address comparison SHALL be unsigned at ADDR_W bits.

Reset
REQ-037 While i_reset=1, the block SHALL hold: state IDLE, o_grant 0, owner register 0, TURN counter 0, o_preempt 0, RR pointer NUM_CH-1 (channel 0 first).
REQ-038 While i_reset=1, all bus outputs and o_driveEn SHALL be 0.
REQ-039 Reset asserted in OWN or TURN SHALL abort immediately; after release the first grant follows REQ-022 timing.

Verification
REQ-040 Fixed priority, NUM_CH=3, TURN_CYC=1: i_req=3'b110 at cycle 0 -> o_grant=3'b010 at cycle 1; drop i_req[1] -> grant 0 for 2 cycles, then 3'b100.
REQ-041 RR_MODE=1: i_req=3'b111 held, each owner drops for one cycle after each grant -> grant order ch0, ch1, ch2, ch0.
REQ-042 Address split: owner addr 16'hBFFE -> o_memExtEn=1, o_memMapEn=0; addr 16'hC000 -> o_memExtEn=0, o_memMapEn=1.
REQ-043 Preemption: ch1 owns, i_force_en=1 with i_force_ch=0 and i_req[0]=1 -> next edge grant 0 and o_preempt=1 for one cycle; after TURN, o_grant=3'b001.
REQ-044 i_disableDrive=1 during OWN -> o_driveEn=0 and o_memExtEn=0; grant unchanged; o_memMapEn still follows the address.
REQ-045 i_reset pulse mid-TURN -> all outputs 0 asynchronously; next i_req=3'b001 -> grant 3'b001 one cycle later.
